// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes
// and the nop bundle that a bubble loads into a pipeline register.
package y86_pkg;

    localparam logic [3:0] IHALT  = 4'h0;
    localparam logic [3:0] INOP   = 4'h1;
    localparam logic [3:0] ICMOV  = 4'h2;
    localparam logic [3:0] IIRMOV = 4'h3;
    localparam logic [3:0] IRMMOV = 4'h4;
    localparam logic [3:0] IMRMOV = 4'h5;
    localparam logic [3:0] IOPQ   = 4'h6;
    localparam logic [3:0] IJXX   = 4'h7;
    localparam logic [3:0] ICALL  = 4'h8;
    localparam logic [3:0] IRET   = 4'h9;
    localparam logic [3:0] IPUSH  = 4'hA;
    localparam logic [3:0] IPOP   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] RRSP   = 4'h4;

    localparam logic [3:0] SAOK   = 4'h1;
    localparam logic [3:0] SHLT   = 4'h2;
    localparam logic [3:0] SADR   = 4'h3;
    localparam logic [3:0] SINS   = 4'h4;

    localparam logic [3:0] FNONE  = 4'h0;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
        logic [3:0]  stat;
    } e_bundle_t;

    // Bundle with configurable "no register" ID, so a top-level override stays consistent.
    function automatic e_bundle_t nop_bundle(input logic [3:0] rnone_id);
        e_bundle_t b;
        b.icode = INOP;
        b.ifun  = FNONE;
        b.valc  = '0;
        b.vala  = '0;
        b.valb  = '0;
        b.dste  = rnone_id;
        b.dstm  = rnone_id;
        b.srca  = rnone_id;
        b.srcb  = rnone_id;
        b.stat  = SAOK;
        return b;
    endfunction

endpackage

// File: rtl/execute_reg_pipe_if.sv
// Decode-to-execute bus: decode-stage values in, registered E-stage values
// and the hazard flags out.
interface execute_reg_pipe_if;
    import y86_pkg::*;

    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  D_stat;

    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [3:0]  E_srcA;
    logic [3:0]  E_srcB;
    logic [3:0]  E_stat;
    logic        load_use;
    logic        mispredict;

    modport master (
        output d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, D_stat,
        input  E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB, E_stat,
               load_use, mispredict
    );

    modport slave (
        input  d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, D_stat,
        output E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB, E_stat,
               load_use, mispredict
    );
endinterface

// File: rtl/e_hazard_detect.sv
// Combinational E-stage hazard detection: load/use on a pending memory read
// and a not-taken conditional jump that was predicted taken.
module e_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] e_icode,
    input  logic [3:0] e_dstm,
    input  logic [3:0] d_srca,
    input  logic [3:0] d_srcb,
    input  logic       e_cnd,
    output logic       load_use,
    output logic       mispredict,
    output logic       bubble
);

    logic is_load;

    assign is_load    = (e_icode == IMRMOV) || (e_icode == IPOP);
    assign load_use   = is_load && (e_dstm != RNONE) &&
                        ((e_dstm == d_srca) || (e_dstm == d_srcb));
    // jmp (ifun 0) always reports e_cnd=1 from execute, so no ifun check is needed.
    assign mispredict = (e_icode == IJXX) && !e_cnd;
    assign bubble     = load_use || mispredict;

endmodule

// File: rtl/execute_reg_pipe.sv
// Decode-to-execute pipeline register with E-stage bubble insertion and
// saturating hazard event counters.
module execute_reg_pipe #(
    parameter int         CNT_W = 32,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    execute_reg_pipe_if.slave bus,
    input  logic             e_Cnd,
    input  logic             hold,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);
    import y86_pkg::*;

    e_bundle_t        e_q, e_d, d_bundle;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
    logic             load_use, mispredict, bubble;

    e_hazard_detect u_hazard (
        .e_icode    (e_q.icode),
        .e_dstm     (e_q.dstm),
        .d_srca     (bus.d_srcA),
        .d_srcb     (bus.d_srcB),
        .e_cnd      (e_Cnd),
        .load_use   (load_use),
        .mispredict (mispredict),
        .bubble     (bubble)
    );

    always_comb begin
        d_bundle.icode = bus.d_icode;
        d_bundle.ifun  = bus.d_ifun;
        d_bundle.valc  = bus.d_valC;
        d_bundle.vala  = bus.d_valA;
        d_bundle.valb  = bus.d_valB;
        d_bundle.dste  = bus.d_dstE;
        d_bundle.dstm  = bus.d_dstM;
        d_bundle.srca  = bus.d_srcA;
        d_bundle.srcb  = bus.d_srcB;
        d_bundle.stat  = bus.D_stat;
    end

    always_comb begin
        e_d          = e_q;
        bubble_cnt_d = bubble_cnt_q;
        lu_cnt_d     = lu_cnt_q;
        mp_cnt_d     = mp_cnt_q;

        if (hold) begin
            e_d = e_q;
        end else if (bubble) begin
            e_d = nop_bundle(RNONE);
        end else begin
            e_d = d_bundle;
        end

        // Clear wins over increment and is honoured while E is frozen.
        if (cnt_clr) begin
            bubble_cnt_d = '0;
            lu_cnt_d     = '0;
            mp_cnt_d     = '0;
        end else if (!hold && bubble) begin
            if (bubble_cnt_q != '1)           bubble_cnt_d = bubble_cnt_q + 1'b1;
            if (load_use   && lu_cnt_q != '1) lu_cnt_d     = lu_cnt_q + 1'b1;
            if (mispredict && mp_cnt_q != '1) mp_cnt_d     = mp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q          <= nop_bundle(RNONE);
            bubble_cnt_q <= '0;
            lu_cnt_q     <= '0;
            mp_cnt_q     <= '0;
        end else begin
            e_q          <= e_d;
            bubble_cnt_q <= bubble_cnt_d;
            lu_cnt_q     <= lu_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
        end
    end

    assign bus.E_icode    = e_q.icode;
    assign bus.E_ifun     = e_q.ifun;
    assign bus.E_valC     = e_q.valc;
    assign bus.E_valA     = e_q.vala;
    assign bus.E_valB     = e_q.valb;
    assign bus.E_dstE     = e_q.dste;
    assign bus.E_dstM     = e_q.dstm;
    assign bus.E_srcA     = e_q.srca;
    assign bus.E_srcB     = e_q.srcb;
    assign bus.E_stat     = e_q.stat;
    assign bus.load_use   = load_use;
    assign bus.mispredict = mispredict;

    assign bubble_cnt = bubble_cnt_q;
    assign lu_cnt     = lu_cnt_q;
    assign mp_cnt     = mp_cnt_q;

endmodule

// File: tb/tb_execute_reg_pipe.sv
// Scoreboard bench for execute_reg_pipe: directed hazard scenarios followed by
// random traffic, checked against a rule-level model of the E register.
module tb_execute_reg_pipe;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef struct {
        logic [3:0]  icode, ifun;
        logic [63:0] valc, vala, valb;
        logic [3:0]  dste, dstm, srca, srcb, stat;
    } mstate_t;

    typedef struct {
        mstate_t          e;
        logic [CNT_W-1:0] bc, lc, mc;
    } exp_t;

    typedef struct {
        logic lu, mp;
    } flags_t;

    logic clk = 1'b0;
    logic rst_n;
    logic e_Cnd, hold, cnt_clr;
    logic [CNT_W-1:0] bubble_cnt, lu_cnt, mp_cnt;

    execute_reg_pipe_if bus ();

    execute_reg_pipe #(.CNT_W(CNT_W), .RNONE(4'hF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .e_Cnd      (e_Cnd),
        .hold       (hold),
        .cnt_clr    (cnt_clr),
        .bubble_cnt (bubble_cnt),
        .lu_cnt     (lu_cnt),
        .mp_cnt     (mp_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t   state_q[$];
    flags_t flag_q[$];

    mstate_t          m_e;
    logic [CNT_W-1:0] m_bc, m_lc, m_mc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mstate_t nop_state();
        mstate_t s;
        s.icode = 4'h1; s.ifun = 4'h0;
        s.valc = '0; s.vala = '0; s.valb = '0;
        s.dste = 4'hF; s.dstm = 4'hF; s.srca = 4'hF; s.srcb = 4'hF;
        s.stat = 4'h1;
        return s;
    endfunction

    task automatic model_reset();
        m_e  = nop_state();
        m_bc = '0; m_lc = '0; m_mc = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_icode"}, bus.E_icode, 4'h1);
        chk({tag, "_ifun"},  bus.E_ifun,  4'h0);
        chk({tag, "_valC"},  bus.E_valC,  64'h0);
        chk({tag, "_valA"},  bus.E_valA,  64'h0);
        chk({tag, "_valB"},  bus.E_valB,  64'h0);
        chk({tag, "_dstE"},  bus.E_dstE,  4'hF);
        chk({tag, "_dstM"},  bus.E_dstM,  4'hF);
        chk({tag, "_srcA"},  bus.E_srcA,  4'hF);
        chk({tag, "_srcB"},  bus.E_srcB,  4'hF);
        chk({tag, "_stat"},  bus.E_stat,  4'h1);
        chk({tag, "_bcnt"},  bubble_cnt,  0);
        chk({tag, "_lcnt"},  lu_cnt,      0);
        chk({tag, "_mcnt"},  mp_cnt,      0);
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CMAX) ? c : c + 1'b1;
    endfunction

    // Apply one cycle of stimulus, predict flags and the post-edge state.
    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] st,
                         input logic cnd, input logic h, input logic clr);
        flags_t f;
        exp_t   x;
        mstate_t dnew;
        bus.d_icode = ic; bus.d_ifun = fn; bus.d_valC = vc; bus.d_valA = va; bus.d_valB = vb;
        bus.d_dstE = de; bus.d_dstM = dm; bus.d_srcA = sa; bus.d_srcB = sb; bus.D_stat = st;
        e_Cnd = cnd; hold = h; cnt_clr = clr;

        f.lu = (m_e.icode == 4'h5 || m_e.icode == 4'hB) && m_e.dstm != 4'hF &&
               (m_e.dstm == sa || m_e.dstm == sb);
        f.mp = (m_e.icode == 4'h7) && !cnd;
        flag_q.push_back(f);

        dnew.icode = ic; dnew.ifun = fn; dnew.valc = vc; dnew.vala = va; dnew.valb = vb;
        dnew.dste = de; dnew.dstm = dm; dnew.srca = sa; dnew.srcb = sb; dnew.stat = st;

        if (clr) begin
            m_bc = '0; m_lc = '0; m_mc = '0;
        end else if (!h && (f.lu || f.mp)) begin
            m_bc = sat_inc(m_bc);
            if (f.lu) m_lc = sat_inc(m_lc);
            if (f.mp) m_mc = sat_inc(m_mc);
        end
        if (!h) m_e = (f.lu || f.mp) ? nop_state() : dnew;

        x.e = m_e; x.bc = m_bc; x.lc = m_lc; x.mc = m_mc;
        state_q.push_back(x);

        @(posedge clk);
        #2;
    endtask

    // Flags are same-cycle: sampled at the falling edge, mid-cycle.
    always @(negedge clk) begin
        flags_t f;
        if (flag_q.size() != 0) begin
            f = flag_q.pop_front();
            chk("load_use", bus.load_use, f.lu);
            chk("mispredict", bus.mispredict, f.mp);
        end
    end

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (state_q.size() != 0) begin
            x = state_q.pop_front();
            chk("E_icode", bus.E_icode, x.e.icode);
            chk("E_ifun",  bus.E_ifun,  x.e.ifun);
            chk("E_valC",  bus.E_valC,  x.e.valc);
            chk("E_valA",  bus.E_valA,  x.e.vala);
            chk("E_valB",  bus.E_valB,  x.e.valb);
            chk("E_dstE",  bus.E_dstE,  x.e.dste);
            chk("E_dstM",  bus.E_dstM,  x.e.dstm);
            chk("E_srcA",  bus.E_srcA,  x.e.srca);
            chk("E_srcB",  bus.E_srcB,  x.e.srcb);
            chk("E_stat",  bus.E_stat,  x.e.stat);
            chk("bubble_cnt", bubble_cnt, x.bc);
            chk("lu_cnt",     lu_cnt,     x.lc);
            chk("mp_cnt",     mp_cnt,     x.mc);
            $display("txn t=%0t E_icode=%0h E_stat=%0h bc=%0d lc=%0d mc=%0d",
                     $time, bus.E_icode, bus.E_stat, bubble_cnt, lu_cnt, mp_cnt);
        end
    end

    initial begin
        logic [3:0] ic, sa, sb;
        logic       cnd;

        rst_n = 1'b1; e_Cnd = 1'b1; hold = 1'b0; cnt_clr = 1'b0;
        #1;
        rst_n = 1'b0;
        bus.d_icode = 4'($urandom); bus.d_ifun = 4'($urandom);
        bus.d_valC = {$urandom, $urandom}; bus.d_valA = {$urandom, $urandom};
        bus.d_valB = {$urandom, $urandom};
        bus.d_dstE = 4'($urandom); bus.d_dstM = 4'($urandom);
        bus.d_srcA = 4'($urandom); bus.d_srcB = 4'($urandom); bus.D_stat = 4'($urandom);
        #1;
        check_reset_outputs("rst");
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // irmovq $0x1234, %rdx
        drive(4'h3, 4'h0, 64'h1234, 64'h0, 64'h0, 4'h2, 4'hF, 4'hF, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
        // mrmovq -> %rbx, then addq reading %rbx: load/use bubble
        drive(4'h5, 4'h0, 64'h8, 64'h0, 64'h55, 4'hF, 4'h3, 4'hF, 4'h6, 4'h1, 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h0, 64'h0, 64'h11, 64'h22, 4'h7, 4'hF, 4'h3, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0);
        // E is nop now; RNONE source must not match
        drive(4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h1, 4'hF, 4'hF, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0);
        // jne not taken -> mispredict; then taken -> no bubble
        drive(4'h7, 4'h4, 64'h400, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
        drive(4'h2, 4'h0, 64'h0, 64'h9, 64'h0, 4'h5, 4'hF, 4'h2, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
        drive(4'h7, 4'h4, 64'h400, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
        drive(4'h2, 4'h0, 64'h0, 64'h9, 64'h0, 4'h5, 4'hF, 4'h2, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
        // hold together with a load/use: nothing moves
        drive(4'hB, 4'h0, 64'h0, 64'h0, 64'h0, 4'h4, 4'h3, 4'h4, 4'h4, 4'h1, 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h3, 4'hF, 4'h3, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0);
        drive(4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h3, 4'hF, 4'h1, 4'h3, 4'h1, 1'b1, 1'b0, 1'b0);
        // 20 load/use bubbles to saturate the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            drive(4'h5, 4'h0, 64'(i), 64'h0, 64'h0, 4'hF, 4'h3, 4'hF, 4'h6, 4'h1, 1'b1, 1'b0, 1'b0);
            drive(4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h3, 4'hF, 4'h3, 4'h3, 4'h1, 1'b1, 1'b0, 1'b0);
        end
        drive(4'h5, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'h3, 4'hF, 4'h6, 4'h1, 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h3, 4'hF, 4'h3, 4'h3, 4'h1, 1'b1, 1'b0, 1'b1);
        // ADR status passes through; swallowed by a mispredict bubble
        drive(4'h4, 4'h0, 64'h10, 64'h1, 64'h2, 4'hF, 4'hF, 4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0);
        drive(4'h7, 4'h1, 64'h80, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
        drive(4'h4, 4'h0, 64'h10, 64'h1, 64'h2, 4'hF, 4'hF, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation, between edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        rst_n = 1'b1;
        drive(4'h3, 4'h0, 64'hBEEF, 64'h0, 64'h0, 4'h6, 4'hF, 4'hF, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            ic  = 4'($urandom_range(0, 11));
            sa  = ($urandom_range(0, 2) == 0) ? m_e.dstm : 4'($urandom);
            sb  = ($urandom_range(0, 3) == 0) ? m_e.dstm : 4'($urandom);
            cnd = (m_e.icode == 4'h7 && m_e.ifun == 4'h0) ? 1'b1 : 1'($urandom);
            drive(ic, 4'($urandom_range(0, 6)), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 4'($urandom), 4'($urandom), sa, sb,
                  4'($urandom_range(1, 4)), cnd,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("drain_state_q", state_q.size(), 0);
        chk("drain_flag_q",  flag_q.size(),  0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
